// File: rtl/xy2_pkg.sv
// xy2_pkg: shared constants and FSM state type for the XY2-100 receiver.
package xy2_pkg;
   localparam logic [2:0] XY2_CTRL_CODE = 3'b001;
   localparam int XY2_FRAME_BITS = 20;
   localparam int XY2_DATA_BITS = 16;
   typedef enum logic {HUNT, DATA} state_t;
endpackage

// File: rtl/xy2_chan_chk.sv
// xy2_chan_chk: per-channel shift register, parity, control-code check and
// optional rejected-frame counter (XY2_RX_ERRCNT_EN).
module xy2_chan_chk import xy2_pkg::*; (
   input  logic clk_ref,
   input  logic sys_rstn,
   input  logic shift,
   input  logic first,
   input  logic check,
   input  logic frame_err,
   input  logic bit_in,
   output logic [XY2_DATA_BITS-1:0] data,
   output logic accept,
   output logic reject,
   output logic [15:0] err_cnt
);
   logic [XY2_FRAME_BITS-2:0] sr;
   logic par;

   always_ff @(posedge clk_ref or negedge sys_rstn)
      if (!sys_rstn) begin
         sr  <= '0;
         par <= 1'b0;
      end else if (shift) begin
         sr  <= {sr[XY2_FRAME_BITS-3:0], bit_in};
         par <= (first ? 1'b0 : par) ^ bit_in;
      end

   // during check, bit_in carries the parity bit itself
   assign accept = check & (sr[XY2_FRAME_BITS-2 -: 3] == XY2_CTRL_CODE) & ~(par ^ bit_in);
   assign reject = frame_err | (check & ~accept);
   assign data   = sr[XY2_DATA_BITS-1:0];

`ifdef XY2_RX_ERRCNT_EN
   always_ff @(posedge clk_ref or negedge sys_rstn)
      if (!sys_rstn)
         err_cnt <= '0;
      else if (reject && err_cnt != 16'hFFFF)
         err_cnt <= err_cnt + 16'd1;
`else
   assign err_cnt = '0;
`endif
endmodule

// File: rtl/xy2_rx.sv
// xy2_rx: XY2-100 command-link receiver with framing, parity/control checks and
// link-loss supervision; define XY2_RX_ERRCNT_EN for rejected-frame counters.
module xy2_rx import xy2_pkg::*; #(
   parameter int TIMEOUT_CYCLES = 200,
   parameter logic [15:0] POS_RESET = 16'h8000
) (
   input  logic clk_ref,
   input  logic sys_rstn,
   input  logic xy_clk,
   input  logic xy_sync,
   input  logic xy_x,
   input  logic xy_y,
   output logic xy_status,
   output logic [15:0] x_pos,
   output logic [15:0] y_pos,
   output logic x_valid,
   output logic y_valid,
   output logic link_lost,
   output logic [15:0] x_err_cnt,
   output logic [15:0] y_err_cnt
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [3:0] s1, s2;
   logic clk_d, xy_edge, fall, sync, tmo;
   logic [TW-1:0] to_cnt;
   logic [4:0] bit_cnt;
   state_t state, nxt;
   logic in_data, last, first, shift, check, stuck, ferr;
   logic acc_x, acc_y, rej_x, rej_y;
   logic [XY2_DATA_BITS-1:0] dat_x, dat_y;

   always_ff @(posedge clk_ref or negedge sys_rstn)
      if (!sys_rstn) begin
         s1    <= '0;
         s2    <= '0;
         clk_d <= 1'b0;
      end else begin
         s1    <= {xy_clk, xy_sync, xy_x, xy_y};
         s2    <= s1;
         clk_d <= s2[3];
      end

   assign xy_edge = s2[3] ^ clk_d;
   assign fall    = clk_d & ~s2[3];
   assign sync    = s2[2];
   assign tmo     = ~xy_edge & (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_ref or negedge sys_rstn)
      if (!sys_rstn)
         to_cnt <= '0;
      else
         to_cnt <= xy_edge ? '0 : (to_cnt == TW'(TIMEOUT_CYCLES)) ? to_cnt : to_cnt + TW'(1);

   always_ff @(posedge clk_ref or negedge sys_rstn)
      if (!sys_rstn)
         state <= HUNT;
      else
         state <= nxt;

   always_comb
      nxt = tmo ? HUNT : (state == HUNT && fall && !sync) ? DATA : stuck ? HUNT : state;

   always_comb begin
      in_data = (state == DATA) & fall;
      last    = bit_cnt == 5'(XY2_FRAME_BITS - 1);
      first   = bit_cnt == '0;
      shift   = in_data & sync & ~last;
      check   = in_data & ~sync & last;
      stuck   = in_data & sync & last;
      ferr    = stuck | (in_data & ~sync & ~last);
   end

   always_ff @(posedge clk_ref or negedge sys_rstn)
      if (!sys_rstn)
         bit_cnt <= '0;
      else
         bit_cnt <= shift ? bit_cnt + 5'd1 : (fall || state == HUNT) ? '0 : bit_cnt;

   xy2_chan_chk u_x (
      .clk_ref(clk_ref), .sys_rstn(sys_rstn), .shift(shift), .first(first),
      .check(check), .frame_err(ferr), .bit_in(s2[1]), .data(dat_x),
      .accept(acc_x), .reject(rej_x), .err_cnt(x_err_cnt));

   xy2_chan_chk u_y (
      .clk_ref(clk_ref), .sys_rstn(sys_rstn), .shift(shift), .first(first),
      .check(check), .frame_err(ferr), .bit_in(s2[0]), .data(dat_y),
      .accept(acc_y), .reject(rej_y), .err_cnt(y_err_cnt));

   always_ff @(posedge clk_ref or negedge sys_rstn)
      if (!sys_rstn) begin
         x_pos     <= POS_RESET;
         y_pos     <= POS_RESET;
         x_valid   <= 1'b0;
         y_valid   <= 1'b0;
         link_lost <= 1'b0;
         xy_status <= 1'b0;
      end else begin
         x_valid   <= acc_x & ~tmo;
         y_valid   <= acc_y & ~tmo;
         x_pos     <= tmo ? POS_RESET : acc_x ? dat_x : x_pos;
         y_pos     <= tmo ? POS_RESET : acc_y ? dat_y : y_pos;
         link_lost <= tmo | (link_lost & ~(acc_x & acc_y));
         xy_status <= tmo | rej_x | rej_y | (xy_status & ~(acc_x & acc_y));
      end
endmodule
